bank_burst_reader: RTL

Initiator-side read engine for one 8-bit x 256 data memory bank. It accepts a burst command of start address and byte count, and drives the bank's Address/MemRead/MemWrite port one byte per cycle. It packs the returned bytes little-endian into 32-bit words and streams them out over a valid/ready interface. It sits between the datapath or DMA logic and a single data-memory bank, which has a combinational read and a synchronous write.

---
 rtl/bank_burst_reader.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/bank_burst_reader.sv
// Burst read engine for one 8-bit data memory bank: issues one byte read per
// cycle and streams the bytes out little-endian packed into 32-bit words.
module bank_burst_reader #(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 9
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [ADDR_W-1:0] StartAddr,
  input  logic [LEN_W-1:0]  Length,
  output logic              Busy,
  output logic              Done,
  output logic [ADDR_W-1:0] BankAddress,
  output logic              BankMemRead,
  output logic              BankMemWrite,
  input  logic [7:0]        BankReadData,
  output logic [31:0]       OutData,
  output logic [3:0]        OutByteEn,
  output logic              OutLast,
  output logic              OutValid,
  input  logic              OutReady
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  localparam logic [LEN_W-1:0]  MAX_LEN  = LEN_W'(1 << ADDR_W);
  localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        lane_q, lane_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       pack_q, pack_d;
  logic [31:0]       out_data_q, out_data_d;
  logic [3:0]        out_be_q, out_be_d;
  logic              out_last_q, out_last_d;
  logic              out_valid_q, out_valid_d;

  logic [LEN_W-1:0]  len_sat;
  logic              last_byte, completes, slot_free, accept, capture;
  logic [31:0]       word_new;
  logic [3:0]        be_new;

  assign len_sat   = (Length > MAX_LEN) ? MAX_LEN : Length;
  assign last_byte = (cnt_q == LEN_ONE);
  assign completes = (lane_q == 2'd3) || last_byte;
  assign slot_free = !out_valid_q || OutReady;
  assign accept    = out_valid_q && OutReady;

  // Pack register with the incoming byte dropped into the current lane; lanes
  // above it are still zero because the pack register clears on every load.
  always_comb begin
    word_new = pack_q;
    word_new[{lane_q, 3'b000} +: 8] = BankReadData;
    case (lane_q)
      2'd0:    be_new = 4'b0001;
      2'd1:    be_new = 4'b0011;
      2'd2:    be_new = 4'b0111;
      default: be_new = 4'b1111;
    endcase
  end

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    addr_d      = addr_q;
    lane_d      = lane_q;
    cnt_d       = cnt_q;
    pack_d      = pack_q;
    out_data_d  = out_data_q;
    out_be_d    = out_be_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;
    capture     = 1'b0;

    if (accept) out_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          addr_d  = StartAddr;
          cnt_d   = len_sat;
          lane_d  = 2'd0;
          pack_d  = '0;
          state_d = (len_sat == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        // A byte that closes a word may only be taken when the output slot frees.
        capture = !completes || slot_free;
        if (capture) begin
          addr_d = addr_q + ADDR_ONE;
          lane_d = lane_q + 2'd1;
          cnt_d  = cnt_q - LEN_ONE;
          if (completes) begin
            out_data_d  = word_new;
            out_be_d    = be_new;
            out_last_d  = last_byte;
            out_valid_d = 1'b1;
            pack_d      = '0;
            if (last_byte) state_d = S_DRAIN;
          end else begin
            pack_d = word_new;
          end
        end
      end
      S_DRAIN: begin
        if (accept) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      lane_q      <= '0;
      cnt_q       <= '0;
      pack_q      <= '0;
      out_data_q  <= '0;
      out_be_q    <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q     <= state_d;
      addr_q      <= addr_d;
      lane_q      <= lane_d;
      cnt_q       <= cnt_d;
      pack_q      <= pack_d;
      out_data_q  <= out_data_d;
      out_be_q    <= out_be_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign Busy         = (state_q == S_READ) || (state_q == S_DRAIN);
  assign Done         = (state_q == S_DONE);
  assign BankAddress  = addr_q;
  assign BankMemRead  = capture;
  assign BankMemWrite = 1'b0;
  assign OutData      = out_data_q;
  assign OutByteEn    = out_be_q;
  assign OutLast      = out_last_q;
  assign OutValid     = out_valid_q;

endmodule
